// File: rtl/bp_cfg_loader_seq_if.sv
// Config-write channel plus microcode ROM read port between bp_cfg_loader_seq and the tile config bus.
// The master modport is the loader side; the slave modport is the bus/ROM side.
interface bp_cfg_loader_seq_if #(
   parameter int num_core_p        = 1,
   parameter int cce_pc_width_p    = 8,
   parameter int cce_instr_width_p = 48,
   parameter int cfg_addr_width_p  = 16,
   parameter int cfg_data_width_p  = 64
);
   localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

   logic                          cfg_v_o;
   logic                          cfg_ready_i;
   logic [core_width_lp-1:0]      cfg_core_o;
   logic [cfg_addr_width_p-1:0]   cfg_addr_o;
   logic [cfg_data_width_p-1:0]   cfg_data_o;
   logic                          ucode_r_v_o;
   logic [cce_pc_width_p-1:0]     ucode_addr_o;
   logic [cce_instr_width_p-1:0]  ucode_data_i;

   modport master (
      output cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_r_v_o, ucode_addr_o,
      input  cfg_ready_i, ucode_data_i
   );

   modport slave (
      input  cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_r_v_o, ucode_addr_o,
      output cfg_ready_i, ucode_data_i
   );
endinterface

// File: rtl/bp_cfg_loader_seq.sv
// Post-reset configuration sequencer: freezes, identifies and loads CCE microcode into every core, then unfreezes all.
// Build option BP_CFG_LOADER_SKIP_UCODE_EN skips the microcode load and programs uncached CCE mode instead.
module bp_cfg_loader_seq #(
   parameter int num_core_p        = 1,
   parameter int cce_pc_width_p    = 8,
   parameter int ucode_els_p       = 256,
   parameter int cce_instr_width_p = 48,
   parameter int cfg_addr_width_p  = 16,
   parameter int cfg_data_width_p  = 64
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   bp_cfg_loader_seq_if.master  cfg_if,
   output logic                 done_o
);
   localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
   // One extra bit so a full-depth ROM load never wraps the entry counter.
   localparam int ucnt_width_lp = cce_pc_width_p + 1;

   localparam logic [core_width_lp-1:0]    core_last_lp  = core_width_lp'(num_core_p - 1);
   localparam logic [ucnt_width_lp-1:0]    ucode_last_lp = ucnt_width_lp'(ucode_els_p - 1);
   localparam logic [core_width_lp-1:0]    core_one_lp   = core_width_lp'(1);
   localparam logic [ucnt_width_lp-1:0]    ucnt_one_lp   = ucnt_width_lp'(1);

   localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(16'h0001);
   localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(16'h0002);
   localparam logic [cfg_addr_width_p-1:0] addr_mode_lp   = cfg_addr_width_p'(16'h0004);
   localparam logic [cfg_addr_width_p-1:0] addr_ucode_lp  = cfg_addr_width_p'(16'h8000);

   localparam logic [cfg_data_width_p-1:0] data_one_lp  = cfg_data_width_p'(1'b1);
   localparam logic [cfg_data_width_p-1:0] data_zero_lp = cfg_data_width_p'(1'b0);
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
   localparam logic [cfg_data_width_p-1:0] mode_data_lp = cfg_data_width_p'(1'b0);
`else
   localparam logic [cfg_data_width_p-1:0] mode_data_lp = cfg_data_width_p'(1'b1);
`endif

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_FREEZE   = 3'd1,
      S_CORE_ID  = 3'd2,
      S_UCODE_RD = 3'd3,
      S_UCODE_WR = 3'd4,
      S_MODE     = 3'd5,
      S_UNFREEZE = 3'd6,
      S_DONE     = 3'd7
   } state_e;

   state_e                        state_q, state_d;
   logic [core_width_lp-1:0]      core_q, core_d;
   logic [ucnt_width_lp-1:0]      ucnt_q, ucnt_d;
   logic                          first_q, first_d;

   logic                          cfg_v_q, cfg_v_d;
   logic [core_width_lp-1:0]      cfg_core_q, cfg_core_d;
   logic [cfg_addr_width_p-1:0]   cfg_addr_q, cfg_addr_d;
   logic [cfg_data_width_p-1:0]   cfg_data_q, cfg_data_d;
   logic                          ucode_r_v_q, ucode_r_v_d;
   logic [cce_pc_width_p-1:0]     ucode_addr_q, ucode_addr_d;
   logic                          done_q, done_d;

   logic                          hs_s;
   logic [cfg_data_width_p-1:0]   rom_word_s;

   assign hs_s       = cfg_v_q & cfg_if.cfg_ready_i;
   assign rom_word_s = cfg_data_width_p'(cfg_if.ucode_data_i);

   // Next-state and counter update; counters are compared against their last value before incrementing.
   always_comb begin
      state_d = state_q;
      core_d  = core_q;
      ucnt_d  = ucnt_q;
      first_d = 1'b0;
      case (state_q)
         S_RESET: begin
            state_d = S_FREEZE;
         end
         S_FREEZE: begin
            if (hs_s) begin
               state_d = S_CORE_ID;
            end else begin
               state_d = S_FREEZE;
            end
         end
         S_CORE_ID: begin
            if (hs_s) begin
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
               state_d = S_MODE;
`else
               state_d = S_UCODE_RD;
`endif
            end else begin
               state_d = S_CORE_ID;
            end
         end
         S_UCODE_RD: begin
            state_d = S_UCODE_WR;
            first_d = 1'b1;
         end
         S_UCODE_WR: begin
            if (hs_s) begin
               if (ucnt_q == ucode_last_lp) begin
                  ucnt_d  = '0;
                  state_d = S_MODE;
               end else begin
                  ucnt_d  = ucnt_q + ucnt_one_lp;
                  state_d = S_UCODE_RD;
               end
            end else begin
               state_d = S_UCODE_WR;
            end
         end
         S_MODE: begin
            if (hs_s) begin
               if (core_q == core_last_lp) begin
                  core_d  = '0;
                  state_d = S_UNFREEZE;
               end else begin
                  core_d  = core_q + core_one_lp;
                  state_d = S_FREEZE;
               end
            end else begin
               state_d = S_MODE;
            end
         end
         S_UNFREEZE: begin
            if (hs_s) begin
               if (core_q == core_last_lp) begin
                  state_d = S_DONE;
               end else begin
                  core_d  = core_q + core_one_lp;
                  state_d = S_UNFREEZE;
               end
            end else begin
               state_d = S_UNFREEZE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // Output decode from the upcoming state so every bus output leaves a flop and holds steady through a stall.
   always_comb begin
      cfg_v_d      = 1'b0;
      cfg_core_d   = '0;
      cfg_addr_d   = '0;
      cfg_data_d   = '0;
      ucode_r_v_d  = 1'b0;
      ucode_addr_d = '0;
      done_d       = 1'b0;
      case (state_d)
         S_FREEZE: begin
            cfg_v_d    = 1'b1;
            cfg_core_d = core_d;
            cfg_addr_d = addr_freeze_lp;
            cfg_data_d = data_one_lp;
         end
         S_CORE_ID: begin
            cfg_v_d    = 1'b1;
            cfg_core_d = core_d;
            cfg_addr_d = addr_core_id_lp;
            cfg_data_d = cfg_data_width_p'(core_d);
         end
         S_UCODE_RD: begin
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
            ucode_r_v_d  = 1'b0;
`else
            ucode_r_v_d  = 1'b1;
`endif
            ucode_addr_d = ucnt_d[cce_pc_width_p-1:0];
         end
         S_UCODE_WR: begin
            cfg_v_d    = 1'b1;
            cfg_core_d = core_d;
            cfg_addr_d = addr_ucode_lp + cfg_addr_width_p'(ucnt_d);
            // ROM word is passed straight through on the first cycle and latched here if the write stalls.
            if (state_q != S_UCODE_WR) begin
               cfg_data_d = data_zero_lp;
            end else if (first_q) begin
               cfg_data_d = rom_word_s;
            end else begin
               cfg_data_d = cfg_data_q;
            end
         end
         S_MODE: begin
            cfg_v_d    = 1'b1;
            cfg_core_d = core_d;
            cfg_addr_d = addr_mode_lp;
            cfg_data_d = mode_data_lp;
         end
         S_UNFREEZE: begin
            cfg_v_d    = 1'b1;
            cfg_core_d = core_d;
            cfg_addr_d = addr_freeze_lp;
            cfg_data_d = data_zero_lp;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         S_RESET: begin
            done_d = 1'b0;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs; reset abandons any in-flight write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_RESET;
         core_q       <= '0;
         ucnt_q       <= '0;
         first_q      <= 1'b0;
         cfg_v_q      <= 1'b0;
         cfg_core_q   <= '0;
         cfg_addr_q   <= '0;
         cfg_data_q   <= '0;
         ucode_r_v_q  <= 1'b0;
         ucode_addr_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_q       <= core_d;
         ucnt_q       <= ucnt_d;
         first_q      <= first_d;
         cfg_v_q      <= cfg_v_d;
         cfg_core_q   <= cfg_core_d;
         cfg_addr_q   <= cfg_addr_d;
         cfg_data_q   <= cfg_data_d;
         ucode_r_v_q  <= ucode_r_v_d;
         ucode_addr_q <= ucode_addr_d;
         done_q       <= done_d;
      end
   end

   assign cfg_if.cfg_v_o      = cfg_v_q;
   assign cfg_if.cfg_core_o   = cfg_core_q;
   assign cfg_if.cfg_addr_o   = cfg_addr_q;
   assign cfg_if.cfg_data_o   = first_q ? rom_word_s : cfg_data_q;
   assign cfg_if.ucode_r_v_o  = ucode_r_v_q;
   assign cfg_if.ucode_addr_o = ucode_addr_q;
   assign done_o              = done_q;
endmodule

// File: tb/tb_bp_cfg_loader_seq.sv
// Bench for bp_cfg_loader_seq: a two-core / four-entry instance under full-rate, backpressured and
// mid-load-reset runs, plus a one-core full-depth (256-entry) instance for the counter boundary.
module tb_bp_cfg_loader_seq;
   logic clk;
   logic rst_m;
   logic rst_b;
   logic done_m;
   logic done_b;

   int n_chk = 0;
   int n_bad = 0;

   bp_cfg_loader_seq_if #(.num_core_p(2), .cce_pc_width_p(8), .cce_instr_width_p(48),
                          .cfg_addr_width_p(16), .cfg_data_width_p(64)) m_if ();
   bp_cfg_loader_seq_if #(.num_core_p(1), .cce_pc_width_p(8), .cce_instr_width_p(48),
                          .cfg_addr_width_p(16), .cfg_data_width_p(64)) b_if ();

   bp_cfg_loader_seq #(.num_core_p(2), .cce_pc_width_p(8), .ucode_els_p(4), .cce_instr_width_p(48),
                       .cfg_addr_width_p(16), .cfg_data_width_p(64)) dut_m (
      .clk_i(clk), .reset_i(rst_m), .cfg_if(m_if.master), .done_o(done_m));

   bp_cfg_loader_seq #(.num_core_p(1), .cce_pc_width_p(8), .ucode_els_p(256), .cce_instr_width_p(48),
                       .cfg_addr_width_p(16), .cfg_data_width_p(64)) dut_b (
      .clk_i(clk), .reset_i(rst_b), .cfg_if(b_if.master), .done_o(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROMs holding 0xA0 + address.
   always @(posedge clk) begin
      if (m_if.ucode_r_v_o) m_if.ucode_data_i <= 48'hA0 + 48'(m_if.ucode_addr_o);
      if (b_if.ucode_r_v_o) b_if.ucode_data_i <= 48'hA0 + 48'(b_if.ucode_addr_o);
   end

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected write idx of a run: per core FREEZE, CORE_ID, ucode entries, MODE; then one UNFREEZE per core.
   function automatic logic [87:0] exp_item(input int ncores, input int els, input int idx);
      int c, r, blk;
      logic [15:0] a;
      logic [63:0] d, md;
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
      blk = 3; md = 64'd0;
`else
      blk = els + 3; md = 64'd1;
`endif
      if (idx < ncores * blk) begin
         c = idx / blk; r = idx % blk;
         if (r == 0)            begin a = 16'h0001; d = 64'd1; end
         else if (r == 1)       begin a = 16'h0002; d = 64'(c); end
         else if (r == blk - 1) begin a = 16'h0004; d = md; end
         else                   begin a = 16'h8000 + 16'(r - 2); d = 64'hA0 + 64'(r - 2); end
      end else begin
         c = idx - ncores * blk; a = 16'h0001; d = 64'd0;
      end
      return {8'(c), a, d};
   endfunction

   // Monitors: collect handshakes and ROM reads, check the bus holds through stalls.
   logic [87:0] m_bus, b_bus, m_bus_prev;
   logic m_hs, b_hs, m_stall_prev, m_rst_prev, m_done_prev, m_hs_prev;
   logic [87:0] m_wq[$], b_wq[$];
   logic [7:0]  m_rq[$], b_rq[$];
   int cyc = 0, first_hs = 0, last_hs = 0;

   assign m_bus = {8'(m_if.cfg_core_o), m_if.cfg_addr_o, m_if.cfg_data_o};
   assign b_bus = {8'(b_if.cfg_core_o), b_if.cfg_addr_o, b_if.cfg_data_o};
   assign m_hs  = m_if.cfg_v_o && m_if.cfg_ready_i;
   assign b_hs  = b_if.cfg_v_o && b_if.cfg_ready_i;

   initial begin
      m_stall_prev = 1'b0; m_rst_prev = 1'b1; m_done_prev = 1'b0; m_hs_prev = 1'b0; m_bus_prev = '0;
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_m) begin
         m_wq.delete();
         m_rq.delete();
      end else begin
         if (m_stall_prev && !m_rst_prev) begin
            chk_eq("stall_v_held", 128'(m_if.cfg_v_o), 128'd1);
            chk_eq("stall_bus_held", 128'(m_bus), 128'(m_bus_prev));
         end
         if (done_m && !m_done_prev) chk_eq("done_after_last_hs", 128'(m_hs_prev), 128'd1);
         if (m_hs) begin
            if (m_wq.size() == 0) first_hs <= cyc;
            last_hs <= cyc;
            m_wq.push_back(m_bus);
         end
         if (m_if.ucode_r_v_o) m_rq.push_back(m_if.ucode_addr_o);
      end
      m_stall_prev <= m_if.cfg_v_o && !m_if.cfg_ready_i;
      m_bus_prev   <= m_bus;
      m_rst_prev   <= rst_m;
      m_done_prev  <= done_m;
      m_hs_prev    <= m_hs;
      if (rst_b) begin
         b_wq.delete();
         b_rq.delete();
      end else begin
         if (b_hs) b_wq.push_back(b_bus);
         if (b_if.ucode_r_v_o) b_rq.push_back(b_if.ucode_addr_o);
      end
   end

   task automatic wait_done_m(input string tag, input int bound);
      for (int i = 0; i < bound && !done_m; i++) @(negedge clk);
      chk_eq(tag, 128'(done_m), 128'd1);
   endtask

   task automatic check_main_stream(input string tag);
      int nw, ne;
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
      nw = 8;  ne = 0;
`else
      nw = 16; ne = 4;
`endif
      chk_eq({tag, "_wr_count"}, 128'(m_wq.size()), 128'(nw));
      for (int i = 0; i < nw && i < m_wq.size(); i++)
         chk_eq($sformatf("%s_wr%0d", tag, i), 128'(m_wq[i]), 128'(exp_item(2, 4, i)));
      chk_eq({tag, "_rd_count"}, 128'(m_rq.size()), 128'(2 * ne));
      for (int i = 0; i < 2 * ne && i < m_rq.size(); i++)
         chk_eq($sformatf("%s_rd%0d", tag, i), 128'(m_rq[i]), 128'(i % 4));
   endtask

   logic [31:0] pat;
   int stall_left;
   logic stalled, found;

   initial begin
      rst_m = 1'b1; rst_b = 1'b1;
      m_if.cfg_ready_i = 1'b0; b_if.cfg_ready_i = 1'b1;
      pat = 32'b1011_0010_1110_0110_1001_1101_0011_0101;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_v", 128'(m_if.cfg_v_o), 128'd0);
      chk_eq("rst_core", 128'(m_if.cfg_core_o), 128'd0);
      chk_eq("rst_addr", 128'(m_if.cfg_addr_o), 128'd0);
      chk_eq("rst_data", 128'(m_if.cfg_data_o), 128'd0);
      chk_eq("rst_rv", 128'(m_if.ucode_r_v_o), 128'd0);
      chk_eq("rst_raddr", 128'(m_if.ucode_addr_o), 128'd0);
      chk_eq("rst_done", 128'(done_m), 128'd0);

      // Full-rate run on both instances.
      @(posedge clk); #1;
      rst_m = 1'b0; rst_b = 1'b0; m_if.cfg_ready_i = 1'b1;
      wait_done_m("a_done", 400);
      check_main_stream("a");
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
      chk_eq("a_span", 128'(last_hs - first_hs + 1), 128'd8);
`else
      chk_eq("a_span", 128'(last_hs - first_hs + 1), 128'd24);
`endif
      repeat (5) @(negedge clk);
      chk_eq("a_done_held", 128'(done_m), 128'd1);
      chk_eq("a_v_low_done", 128'(m_if.cfg_v_o), 128'd0);

      for (int i = 0; i < 1200 && !done_b; i++) @(negedge clk);
      chk_eq("big_done", 128'(done_b), 128'd1);
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
      chk_eq("big_wr_count", 128'(b_wq.size()), 128'd4);
      chk_eq("big_rd_count", 128'(b_rq.size()), 128'd0);
`else
      chk_eq("big_wr_count", 128'(b_wq.size()), 128'd260);
      for (int i = 0; i < 260 && i < b_wq.size(); i++)
         chk_eq($sformatf("big_wr%0d", i), 128'(b_wq[i]), 128'(exp_item(1, 256, i)));
      if (b_wq.size() == 260) begin
         chk_eq("big_last_ucode", 128'(b_wq[257]), 128'({8'd0, 16'h80FF, 64'h19F}));
         chk_eq("big_mode_next", 128'(b_wq[258]), 128'({8'd0, 16'h0004, 64'd1}));
      end
      chk_eq("big_rd_count", 128'(b_rq.size()), 128'd256);
      for (int i = 0; i < 256 && i < b_rq.size(); i++)
         chk_eq($sformatf("big_rd%0d", i), 128'(b_rq[i]), 128'(i));
`endif

      // Backpressure run with a 10-cycle stall on the first write to 0x8002.
      @(posedge clk); #1; rst_m = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst_m = 1'b0;
      stalled = 1'b0; stall_left = 0;
      for (int k = 0; k < 1500 && !done_m; k++) begin
         if (!stalled && m_if.cfg_v_o && m_if.cfg_addr_o == 16'h8002) begin
            stalled = 1'b1; stall_left = 10;
         end
         if (stall_left > 0) begin
            m_if.cfg_ready_i = 1'b0; stall_left--;
         end else begin
            m_if.cfg_ready_i = pat[k % 32];
         end
         @(posedge clk); #1;
      end
      m_if.cfg_ready_i = 1'b1;
      wait_done_m("b_done", 50);
`ifndef BP_CFG_LOADER_SKIP_UCODE_EN
      chk_eq("b_stall_hit", 128'(stalled), 128'd1);
`endif
      check_main_stream("b");

      // Reset while core 1 holds a microcode write pending.
      @(posedge clk); #1; rst_m = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst_m = 1'b0; m_if.cfg_ready_i = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(posedge clk); #1;
`ifdef BP_CFG_LOADER_SKIP_UCODE_EN
         if (m_if.cfg_v_o && m_if.cfg_core_o == 1'b1 && m_if.cfg_addr_o == 16'h0002) found = 1'b1;
`else
         if (m_if.cfg_v_o && m_if.cfg_core_o == 1'b1 && m_if.cfg_addr_o[15]) found = 1'b1;
`endif
      end
      chk_eq("c_found_target", 128'(found), 128'd1);
      m_if.cfg_ready_i = 1'b0; rst_m = 1'b1;
      @(posedge clk); #1;
      rst_m = 1'b0; m_if.cfg_ready_i = 1'b1;
      @(negedge clk);
      chk_eq("c_v_dropped", 128'(m_if.cfg_v_o), 128'd0);
      wait_done_m("c_done", 400);
      if (m_wq.size() > 0) chk_eq("c_first_wr", 128'(m_wq[0]), 128'({8'd0, 16'h0001, 64'd1}));
      check_main_stream("c");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/bp_cfg_loader_seq.md
Name: bp_cfg_loader_seq

Overview:
- Post-reset configuration sequencer for the tile array.
- Walks every core (0..num_core_p-1) over a single valid/ready config-write channel:
  - freezes the core;
  - programs its core ID;
  - streams CCE microcode from a synchronous ROM;
  - sets the CCE mode.
- After all cores are programmed, unfreezes them in order. Sits between the top-level ROM and the per-tile config bus; asserts done_o when finished.

Parameters:
- num_core_p, 1, number of cores to configure (proc-param num_core).
- cce_pc_width_p, 8, CCE microcode address width; ROM depth = 2**cce_pc_width_p.
- ucode_els_p, 256, microcode entries to load; 1..2**cce_pc_width_p.
- cce_instr_width_p, 48, microcode word width.
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 64, config data width; must be >= cce_instr_width_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cfg_v_o  out  1  config write valid
- cfg_ready_i  in  1  config channel ready; a write transfers when cfg_v_o & cfg_ready_i
- cfg_core_o  out  clog2(num_core_p) (safe)  destination core
- cfg_addr_o  out  cfg_addr_width_p  register address
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended
- ucode_r_v_o  out  1  ROM read strobe
- ucode_addr_o  out  cce_pc_width_p  ROM address
- ucode_data_i  in  cce_instr_width_p  ROM data, valid the cycle after ucode_r_v_o
- done_o  out  1  sequence complete

Behaviour:
- Register map:
  - FREEZE = 0x0001: data 1 freezes, data 0 unfreezes.
  - CORE_ID = 0x0002: data = core index.
  - CCE_MODE = 0x0004: data 1 = normal, 0 = uncached.
  - UCODE = 0x8000 + entry index.
- Reset: state=RESET; core counter and ucode counter cleared. All outputs 0: cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_r_v_o, ucode_addr_o, done_o.
- States and transitions:
  - RESET -> FREEZE on the first cycle with reset_i low.
  - FREEZE: v=1, addr 0x0001, data 1. On handshake -> CORE_ID.
  - CORE_ID: addr 0x0002, data = core counter. On handshake -> UCODE_RD.
  - UCODE_RD: one cycle. ucode_r_v_o=1, ucode_addr_o = ucode counter, cfg_v_o=0. -> UCODE_WR.
  - UCODE_WR:
    - Cycle 1: capture ucode_data_i into a holding register.
    - v=1 with addr 0x8000 + counter and data = holding register; held until handshake.
    - On handshake: if counter == ucode_els_p-1, clear the counter and go to MODE; else increment and go to UCODE_RD.
  - MODE: addr 0x0004, data 1. On handshake: if core counter == num_core_p-1, clear it and go to UNFREEZE; else increment and go to FREEZE.
  - UNFREEZE: addr 0x0001, data 0, cfg_core_o = core counter. On handshake: at the last core -> DONE; else increment.
  - DONE: done_o=1, cfg_v_o=0. Held until reset.
- Handshake:
  - Once cfg_v_o rises, cfg_core_o/addr_o/data_o stay stable until the handshake completes.
  - cfg_v_o never depends combinationally on cfg_ready_i.
  - With ready held high: one write per cycle in FREEZE/ID/MODE/UNFREEZE; one write per 2 cycles in the ucode phase.
- Write counts:
  - Total writes = num_core_p*(ucode_els_p+3) + num_core_p.
  - ROM reads = num_core_p*ucode_els_p; each address is read exactly once per core.
- Counter wrap: counters are compared against els-1 before incrementing. No overflow when ucode_els_p = 2**cce_pc_width_p; the counter is one bit wider internally.
- num_core_p=1: cfg_core_o is a 1-bit constant 0.
- Reset mid-operation: abandons any in-flight write (cfg_v_o low the next cycle) and restarts from FREEZE at core 0. No partial state is retained.
- cfg_ready_i asserted while cfg_v_o=0 is ignored.

Optional Feature:
- Macro: BP_CFG_LOADER_SKIP_UCODE_EN.
- Defined:
  - UCODE_RD and UCODE_WR are never entered; CORE_ID goes directly to MODE.
  - MODE writes data 0 (uncached).
  - ucode_r_v_o is tied 0.
  - Total writes = 4*num_core_p.
- Undefined: full sequence as above.

Test Plan:
- num_core_p=1, ucode_els_p=4, ready always 1, ROM[i]=0xA0+i:
  - 8 writes, in order: (0x0001,1) (0x0002,0) (0x8000,0xA0) (0x8001,0xA1) (0x8002,0xA2) (0x8003,0xA3) (0x0004,1) (0x0001,0).
  - done_o high from the cycle after the last handshake.
- Backpressure: ready toggles on a random pattern, including a 10-cycle stall mid-ucode:
  - identical write stream;
  - core/addr/data stable throughout every stall;
  - no duplicate or lost writes.
- num_core_p=2, ucode_els_p=4:
  - 16 writes.
  - Core 0 block (7 writes), then core 1 block (7 writes), then unfreeze core 0, then unfreeze core 1.
  - 8 ROM reads.
- Reset asserted during core 1's UCODE_WR with v high:
  - cfg_v_o goes 0.
  - After release, the next write is (core 0, 0x0001, 1).
- BP_CFG_LOADER_SKIP_UCODE_EN defined, num_core_p=2:
  - 8 writes, each MODE write has data 0.
  - ucode_r_v_o never asserts.
  - done_o asserts.
- ucode_els_p=256, cce_pc_width_p=8: last ucode write goes to addr 0x80FF, followed directly by MODE. No counter wrap to entry 0.
